float_to_fixed: RTL and testbench
=================================

# float_to_fixed

Pipelined converter from IEEE half- or single-precision floating point to the team's signed FIXED_XX_XX format, where XX_XX gives integer and fraction bits. It accepts one float per cycle on a valid/ready stream and produces the two's-complement fixed value with saturation and NaN/overflow flags. It is the return path for float-domain results feeding the fixed-point datapaths. Its precision strings match the ones the constant generators use, so constants and converted results share a format.

## Interface
- IN_PRECISION, "SINGLE": "HALF" or "SINGLE".
- IN_BITS, 32: 16 for HALF, 32 for SINGLE.
- OUT_PRECISION, "FIXED_16_16": FRACTION is parsed from the last two ASCII digits.
- OUT_BITS, 32: output width, signed two's complement.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  IN_BITS  float operand.
- in_valid  in  1  operand present.
- in_ready  out  1  converter can accept.
- out_data  out  OUT_BITS  fixed result.
- out_nan  out  1  input was NaN.
- out_ovf  out  1  result saturated (including ±inf).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.

## Operation
- Stage 1 (unpack):
  - Split the operand into sign, exponent and mantissa; restore the hidden 1.
  - Classify as zero (exp==0; subnormals flush to zero), inf (exp all-ones, mant==0), NaN (exp all-ones, mant!=0), or normal.
- Stage 2 (align):
  - sh = (exp − bias) − MANT_BITS + FRACTION, where bias and MANT_BITS are 15/10 for HALF and 127/23 for SINGLE.
  - sh ≥ 0: shift the magnitude left into an OUT_BITS+1 wide field; any bit lost above that field sets the pre-overflow flag.
  - sh < 0: shift right; keep guard and sticky bits. If shifting right by more than the field width, the magnitude is 0 and only sticky survives.
- Stage 3 (round, saturate, sign):
  - Round the magnitude (see Configuration), then apply the sign.
  - Positive results above 2^(OUT_BITS−1)−1 clamp to 0x7FF…F with out_ovf=1.
  - Negative results with magnitude above 2^(OUT_BITS−1) clamp to 0x800…0 with out_ovf=1.
  - A magnitude of exactly 2^(OUT_BITS−1) with a negative sign is exact: no ovf.
  - A rounding carry that crosses the limit saturates.
  - +inf → 0x7FF…F, −inf → 0x800…0, both with ovf=1.
  - NaN → 0 with out_nan=1 and ovf=0.
  - Zero and −0 → 0 with no flags.
- Handshake:
  - A transfer occurs on any edge where valid&ready.
  - Global stall: adv = ~out_valid | out_ready.
  - in_ready = adv, combinational from registered state and out_ready.
  - When adv=0, all stage registers hold.
  - When adv=1, stage valids shift; bubbles propagate as valid=0.
- out_data and the flags are stable while out_valid=1 and out_ready=0.

## Timing
- Reset: stage valids, out_valid, out_data, out_nan and out_ovf all go to 0. in_ready is 1 out of reset.
- Latency: an operand accepted at edge N has out_valid=1 after edge N+3 when there is no stall.
- Throughput: one result per cycle while out_ready=1.
- Stall: with out_ready low and out_valid high, in_ready=0 in the same cycle; no operand is lost or duplicated. Holding out_ready=0 for k cycles delays every in-flight item by exactly k cycles.
- Reset asserted mid-stream: in-flight items are discarded and out_valid=0 on the following cycle. in_valid is ignored while rst=1.
- No combinational path from in_data or in_valid to any output.

## Configuration
- FLOAT_TO_FIXED_ROUND_EN defined: round to nearest even on the magnitude, using the guard bit, the sticky bit and the LSB.
- Not defined: truncate the magnitude (round toward zero). Guard and sticky logic is not compiled.
- Saturation and flags are identical in both builds.

## Test plan
- SINGLE→FIXED_16_16 basics: 3F800000 → 00010000, BF800000 → FFFF0000, 3F000000 → 00008000, C0000000 → FFFE0000; each with latency 3.
- Saturation boundaries:
  - 47000000 (32768.0) → 7FFFFFFF, ovf=1.
  - C7000000 (−32768.0) → 80000000, ovf=0.
  - FF800000 → 80000000, ovf=1.
  - 7FC00000 → 00000000, nan=1.
- Rounding:
  - 37C00000 (1.5 LSB) → 00000002 with ROUND_EN, 00000001 without.
  - B7C00000 → FFFFFFFE with ROUND_EN, FFFFFFFF without.
  - 33800000 → 00000000 in both builds.
- Backpressure: stream 8 operands back-to-back with out_ready toggling at random. Required: outputs arrive in order, none are dropped or duplicated, and data holds while stalled.
- Reset mid-stream: assert rst for 1 cycle with 3 items in flight. Required: out_valid=0 the next cycle and no stale result appears afterward.
- HALF→FIXED_08_08 (OUT_BITS=16): 3C00 → 0100, BC00 → FF00, 5C00 (256.0) → 7FFF with ovf=1, 0001 (subnormal) → 0000.

Source files
------------

// File: rtl/float_to_fixed_if.sv
// float_to_fixed_if: valid/ready operand stream in, fixed-point result stream out.
interface float_to_fixed_if #(
    parameter int IN_BITS  = 32,
    parameter int OUT_BITS = 32
);
    logic [IN_BITS-1:0]  in_data;
    logic                in_valid;
    logic                in_ready;
    logic [OUT_BITS-1:0] out_data;
    logic                out_nan;
    logic                out_ovf;
    logic                out_valid;
    logic                out_ready;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_nan, out_ovf, out_valid);
    modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_nan, out_ovf, out_valid);
endinterface

// File: rtl/float_to_fixed.sv
// float_to_fixed: pipelined IEEE half/single float to saturating signed fixed-point converter.
// FLOAT_TO_FIXED_ROUND_EN selects round-to-nearest-even; otherwise the magnitude truncates.
module float_to_fixed #(
    parameter     IN_PRECISION  = "SINGLE",
    parameter int IN_BITS       = 32,
    parameter     OUT_PRECISION = "FIXED_16_16",
    parameter int OUT_BITS      = 32
) (
    input logic clk,
    input logic rst,
    float_to_fixed_if.slave bus
);
    localparam bit IS_HALF   = IN_PRECISION[31:0] == "HALF";
    localparam int MANT_BITS = IS_HALF ? 10 : 23;
    localparam int EXP_BITS  = IS_HALF ? 5 : 8;
    localparam int BIAS      = IS_HALF ? 15 : 127;
    localparam int FRACTION  = (int'(OUT_PRECISION[15:8]) - 48) * 10 + int'(OUT_PRECISION[7:0]) - 48;
    localparam int MW        = MANT_BITS + 1;
    localparam int W         = OUT_BITS + 1;
    localparam int W1        = W + 1;
    localparam int WIDE      = W + MW;
    localparam logic [W1-1:0]       LIM = W1'(1) << (OUT_BITS - 1);
    localparam logic [OUT_BITS-1:0] MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
    localparam logic [OUT_BITS-1:0] MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

    logic adv;
    logic s1_v, s2_v, s3_v, out_v, out_n, out_o;
    logic [IN_BITS-1:0] s1_d;
    logic s2_sign, s2_zero, s2_inf, s2_nan;
    logic [EXP_BITS-1:0] s2_exp;
    logic [MW-1:0] s2_mant;
    logic s3_sign, s3_zero, s3_inf, s3_nan, s3_ovf;
    logic [W-1:0] s3_mag;
    logic [OUT_BITS-1:0] out_d;
    logic [EXP_BITS-1:0] u_exp;
    logic [MANT_BITS-1:0] u_frac;
    logic u_max;
    int sh, r;
    logic a_ovf;
    logic [W-1:0] a_mag;
    logic [W1-1:0] rnd;
    logic big;
    logic [OUT_BITS-1:0] r_data;
`ifdef FLOAT_TO_FIXED_ROUND_EN
    logic s3_g, s3_s, a_g, a_s;
    logic [MW-1:0] fr;
`endif

    assign adv = ~out_v | bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_v;
    assign bus.out_data = out_d;
    assign bus.out_nan = out_n;
    assign bus.out_ovf = out_o;

    always_comb begin
        u_exp = s1_d[IN_BITS-2 -: EXP_BITS];
        u_frac = s1_d[MANT_BITS-1:0];
        u_max = &u_exp;
    end

    // Right shifts past the whole mantissa leave only sticky; the hidden bit makes it nonzero.
    always_comb begin
        sh = int'(s2_exp) - BIAS - MANT_BITS + FRACTION;
        r = -sh;
        a_ovf = MANT_BITS + sh >= W;
        a_mag = sh >= 0 ? W'(WIDE'(s2_mant) << sh) : r > MW ? '0 : W'(s2_mant >> r);
`ifdef FLOAT_TO_FIXED_ROUND_EN
        fr = MW'({s2_mant, MW'(0)} >> r);
        a_g = sh >= 0 ? 1'b0 : r > MW ? 1'b0 : fr[MW-1];
        a_s = sh >= 0 ? 1'b0 : r > MW ? 1'b1 : |fr[MW-2:0];
`endif
    end

    always_comb begin
`ifdef FLOAT_TO_FIXED_ROUND_EN
        rnd = {1'b0, s3_mag} + W1'(s3_g & (s3_s | s3_mag[0]));
`else
        rnd = {1'b0, s3_mag};
`endif
        big = s3_inf | s3_ovf | (s3_sign ? rnd > LIM : rnd >= LIM);
        r_data = (s3_nan | s3_zero) ? '0 : big ? (s3_sign ? MIN : MAX) : s3_sign ? OUT_BITS'(-rnd) : OUT_BITS'(rnd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
            out_v <= 1'b0;
            out_d <= '0;
            out_n <= 1'b0;
            out_o <= 1'b0;
        end else if (adv) begin
            s1_v <= bus.in_valid;
            s1_d <= bus.in_data;
            s2_v <= s1_v;
            s2_sign <= s1_d[IN_BITS-1];
            s2_exp <= u_exp;
            s2_mant <= {1'b1, u_frac};
            s2_zero <= u_exp == '0;
            s2_inf <= u_max & (u_frac == '0);
            s2_nan <= u_max & (u_frac != '0);
            s3_v <= s2_v;
            s3_sign <= s2_sign;
            s3_zero <= s2_zero;
            s3_inf <= s2_inf;
            s3_nan <= s2_nan;
            s3_ovf <= a_ovf;
            s3_mag <= a_mag;
`ifdef FLOAT_TO_FIXED_ROUND_EN
            s3_g <= a_g;
            s3_s <= a_s;
`endif
            out_v <= s3_v;
            out_d <= r_data;
            out_n <= s3_nan;
            out_o <= ~s3_nan & ~s3_zero & big;
        end
    end
endmodule

// File: tb/tb_float_to_fixed.sv
// tb_float_to_fixed: directed checks of the SINGLE->FIXED_16_16 and HALF->FIXED_08_08 converters.
module tb_float_to_fixed;
    logic clk = 0;
    logic rst = 1;
    int n_vec = 0;
    int n_err = 0;

`ifdef FLOAT_TO_FIXED_ROUND_EN
    localparam logic [31:0] R_POS = 32'h0000_0002, R_NEG = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] R_POS = 32'h0000_0001, R_NEG = 32'hFFFF_FFFF;
`endif

    always #5 clk = ~clk;

    float_to_fixed_if #(.IN_BITS(32), .OUT_BITS(32)) b ();
    float_to_fixed_if #(.IN_BITS(16), .OUT_BITS(16)) h ();

    float_to_fixed #(.IN_PRECISION("SINGLE"), .IN_BITS(32), .OUT_PRECISION("FIXED_16_16"), .OUT_BITS(32))
        dut (.clk(clk), .rst(rst), .bus(b));
    float_to_fixed #(.IN_PRECISION("HALF"), .IN_BITS(16), .OUT_PRECISION("FIXED_08_08"), .OUT_BITS(16))
        dut16 (.clk(clk), .rst(rst), .bus(h));

    task automatic send32(input logic [31:0] f, output logic [31:0] d, output logic n, output logic o, output int lat);
        b.in_data = f;
        b.in_valid = 1;
        b.out_ready = 1;
        @(posedge clk); #1;
        b.in_valid = 0;
        lat = 0;
        while (!b.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        d = b.out_data;
        n = b.out_nan;
        o = b.out_ovf;
    endtask

    task automatic send16(input logic [15:0] f, output logic [15:0] d, output logic n, output logic o, output int lat);
        h.in_data = f;
        h.in_valid = 1;
        h.out_ready = 1;
        @(posedge clk); #1;
        h.in_valid = 0;
        lat = 0;
        while (!h.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        d = h.out_data;
        n = h.out_nan;
        o = h.out_ovf;
    endtask

    task automatic test_reset;
        rst = 1;
        b.in_valid = 1;
        b.in_data = 32'h3F80_0000;
        b.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        b.in_valid = 0;
        rst = 0;
        b.out_ready = 0;
        #1;
        n_vec++;
        if ({b.out_valid, b.out_nan, b.out_ovf} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000", {b.out_valid, b.out_nan, b.out_ovf});
        end
        n_vec++;
        if (b.out_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 00000000", b.out_data);
        end
        n_vec++;
        if (b.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", b.in_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (b.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_accept: got out_valid %b want 0", b.out_valid);
        end
        b.out_ready = 1;
    endtask

    task automatic test_basic;
        logic [31:0] ops [4] = '{32'h3F80_0000, 32'hBF80_0000, 32'h3F00_0000, 32'hC000_0000};
        logic [31:0] exp [4] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000, 32'hFFFE_0000};
        logic [31:0] d;
        logic n, o;
        int lat;
        for (int i = 0; i < 4; i++) begin
            send32(ops[i], d, n, o, lat);
            n_vec++;
            if (lat !== 3) begin
                n_err++;
                $display("FAIL basic_latency[%0d]: got %0d want 3", i, lat);
            end
            n_vec++;
            if ({d, n, o} !== {exp[i], 2'b00}) begin
                n_err++;
                $display("FAIL basic[%0d] %h: got %h nan=%b ovf=%b want %h nan=0 ovf=0", i, ops[i], d, n, o, exp[i]);
            end
        end
    endtask

    task automatic test_saturation;
        logic [31:0] ops [6] = '{32'h4700_0000, 32'hC700_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h8000_0000};
        logic [31:0] exp [6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        logic [1:0] fl [6] = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
        logic [31:0] d;
        logic n, o;
        int lat;
        for (int i = 0; i < 6; i++) begin
            send32(ops[i], d, n, o, lat);
            n_vec++;
            if ({d, n, o} !== {exp[i], fl[i]}) begin
                n_err++;
                $display("FAIL sat[%0d] %h: got %h nan/ovf=%b%b want %h nan/ovf=%b", i, ops[i], d, n, o, exp[i], fl[i]);
            end
        end
        send32(32'h7F80_0000, d, n, o, lat);
        n_vec++;
        if ({d, n, o} !== {32'h7FFF_FFFF, 2'b01}) begin
            n_err++;
            $display("FAIL sat_pos_inf: got %h nan/ovf=%b%b want 7fffffff nan/ovf=01", d, n, o);
        end
    endtask

    task automatic test_rounding;
        logic [31:0] ops [3] = '{32'h37C0_0000, 32'hB7C0_0000, 32'h3380_0000};
        logic [31:0] exp [3] = '{R_POS, R_NEG, 32'h0000_0000};
        logic [31:0] d;
        logic n, o;
        int lat;
        for (int i = 0; i < 3; i++) begin
            send32(ops[i], d, n, o, lat);
            n_vec++;
            if ({d, n, o} !== {exp[i], 2'b00}) begin
                n_err++;
                $display("FAIL round[%0d] %h: got %h nan/ovf=%b%b want %h nan/ovf=00", i, ops[i], d, n, o, exp[i]);
            end
        end
    endtask

    task automatic test_half;
        logic [15:0] ops [4] = '{16'h3C00, 16'hBC00, 16'h5C00, 16'h0001};
        logic [15:0] exp [4] = '{16'h0100, 16'hFF00, 16'h7FFF, 16'h0000};
        logic [1:0] fl [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
        logic [15:0] d;
        logic n, o;
        int lat;
        for (int i = 0; i < 4; i++) begin
            send16(ops[i], d, n, o, lat);
            n_vec++;
            if ({d, n, o, lat} !== {exp[i], fl[i], 32'd3}) begin
                n_err++;
                $display("FAIL half[%0d] %h: got %h nan/ovf=%b%b lat=%0d want %h nan/ovf=%b lat=3", i, ops[i], d, n, o, lat, exp[i], fl[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ops [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                                 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
        int ii = 0;
        int oi = 0;
        logic held_v = 0;
        logic [31:0] held_d = 0;
        logic [31:0] want;
        logic extra = 0;
        @(posedge clk); #1;
        for (int c = 0; c < 300 && oi < 8; c++) begin
            b.out_ready = 1'($urandom_range(0, 1));
            b.in_valid = ii < 8;
            b.in_data = ops[ii[2:0]];
            #1;
            if (held_v) begin
                n_vec++;
                if ({b.out_valid, b.out_data} !== {1'b1, held_d}) begin
                    n_err++;
                    $display("FAIL b2b_hold: got v=%b %h want v=1 %h", b.out_valid, b.out_data, held_d);
                end
            end
            if (b.out_valid && !b.out_ready) begin
                n_vec++;
                if (b.in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_stall_in_ready: got %b want 0", b.in_ready);
                end
            end
            if (b.out_valid && b.out_ready) begin
                want = 32'(oi + 1) << 16;
                n_vec++;
                if (b.out_data !== want) begin
                    n_err++;
                    $display("FAIL b2b_order[%0d]: got %h want %h", oi, b.out_data, want);
                end
                oi++;
            end
            if (b.in_valid && b.in_ready) ii++;
            held_v = b.out_valid && !b.out_ready;
            held_d = b.out_data;
            @(posedge clk); #1;
        end
        n_vec++;
        if (oi !== 8) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results want 8", oi);
        end
        b.in_valid = 0;
        b.out_ready = 1;
        repeat (5) begin
            #1;
            extra = extra | b.out_valid;
            @(posedge clk); #1;
        end
        n_vec++;
        if (extra !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_duplicate: got extra out_valid %b want 0", extra);
        end
    endtask

    task automatic test_reset_midstream;
        logic [31:0] ops [3] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        logic stale = 0;
        logic [31:0] d;
        logic n, o;
        int lat;
        b.out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            b.in_data = ops[i];
            b.in_valid = 1;
            @(posedge clk); #1;
        end
        b.in_valid = 1;
        b.in_data = 32'h4080_0000;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        b.in_valid = 0;
        n_vec++;
        if (b.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_valid: got %b want 0", b.out_valid);
        end
        repeat (6) begin
            stale = stale | b.out_valid;
            @(posedge clk); #1;
        end
        n_vec++;
        if (stale !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_stale: got out_valid %b want 0", stale);
        end
        send32(32'hC000_0000, d, n, o, lat);
        n_vec++;
        if ({d, n, o, lat} !== {32'hFFFE_0000, 2'b00, 32'd3}) begin
            n_err++;
            $display("FAIL rst_mid_recover: got %h nan/ovf=%b%b lat=%0d want fffe0000 nan/ovf=00 lat=3", d, n, o, lat);
        end
    endtask

    initial begin
        b.in_valid = 0;
        b.in_data = 0;
        b.out_ready = 1;
        h.in_valid = 0;
        h.in_data = 0;
        h.out_ready = 1;
        test_reset;
        test_basic;
        test_saturation;
        test_rounding;
        test_half;
        test_back_to_back;
        test_reset_midstream;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
